// File: rtl/xdma_finish_sender.sv
// rtl/xdma_finish_sender.sv - queues finish requests and sends each as one remote write
// Head entry stays in the queue until its write response arrives, then it is popped.
module xdma_finish_sender #(
  parameter int AddrWidth = 48,
  parameter int IdWidth   = 8,
  parameter int DataWidth = 512,
  parameter int Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 finish_valid_i,
  output logic                 finish_ready_o,
  input  logic [AddrWidth-1:0] finish_addr_i,
  input  logic [IdWidth-1:0]   finish_dma_id_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic                 b_error_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [15:0]          sent_count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [AddrWidth-1:0] addr_mem [Depth];
  logic [IdWidth-1:0]   id_mem   [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW:0]        count;

  logic [1:0]  state;
  logic        aw_done;
  logic        w_done;
  logic        err_q;
  logic [15:0] sent_count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic aw_hs;
  logic w_hs;
  logic send_exit;

  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  // Ready comes from registered occupancy only, so a full queue never accepts in the pop cycle.
  assign finish_ready_o = !full;
  assign push           = finish_valid_i && !full;
  assign pop            = (state == ST_RESP) && b_valid_i;

  assign aw_valid_o = (state == ST_SEND) && !aw_done;
  assign w_valid_o  = (state == ST_SEND) && !w_done;
  assign b_ready_o  = (state == ST_RESP);

  assign aw_hs     = aw_valid_o && aw_ready_i;
  assign w_hs      = w_valid_o && w_ready_i;
  assign send_exit = (aw_done || aw_hs) && (w_done || w_hs);

  assign aw_addr_o    = addr_mem[rd_ptr];
  assign w_data_o     = {{(DataWidth - IdWidth){1'b0}}, id_mem[rd_ptr]};
  assign busy_o       = !empty || (state != ST_IDLE);
  assign err_o        = err_q;
  assign sent_count_o = sent_count_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= finish_addr_i;
      id_mem[wr_ptr]   <= finish_dma_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      err_q        <= 1'b0;
      sent_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_SEND;
        end
        ST_SEND: begin
          if (send_exit) begin
            state   <= ST_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (b_valid_i) begin
            state        <= ST_IDLE;
            sent_count_q <= sent_count_q + 16'd1;
            if (b_error_i) err_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_finish_sender.sv
// tb/tb_xdma_finish_sender.sv - directed self-checking bench for xdma_finish_sender
module tb_xdma_finish_sender;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         finish_valid = 1'b0;
  logic         finish_ready;
  logic [47:0]  finish_addr = '0;
  logic [7:0]   finish_dma_id = '0;
  logic         aw_valid;
  logic         aw_ready = 1'b0;
  logic [47:0]  aw_addr;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [511:0] w_data;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic         b_error = 1'b0;
  logic         busy;
  logic         err;
  logic [15:0]  sent_count;

  int total = 0;
  int bad   = 0;

  xdma_finish_sender dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .finish_valid_i (finish_valid),
    .finish_ready_o (finish_ready),
    .finish_addr_i  (finish_addr),
    .finish_dma_id_i(finish_dma_id),
    .aw_valid_o     (aw_valid),
    .aw_ready_i     (aw_ready),
    .aw_addr_o      (aw_addr),
    .w_valid_o      (w_valid),
    .w_ready_i      (w_ready),
    .w_data_o       (w_data),
    .b_valid_i      (b_valid),
    .b_ready_o      (b_ready),
    .b_error_i      (b_error),
    .busy_o         (busy),
    .err_o          (err),
    .sent_count_o   (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_one(input logic [47:0] a, input logic [7:0] id);
    finish_valid  = 1'b1;
    finish_addr   = a;
    finish_dma_id = id;
    step();
    finish_valid  = 1'b0;
  endtask

  task automatic reset_outputs(input string pfx);
    check({pfx, "_ready"},  finish_ready, 1);
    check({pfx, "_aw"},     aw_valid, 0);
    check({pfx, "_w"},      w_valid, 0);
    check({pfx, "_bready"}, b_ready, 0);
    check({pfx, "_busy"},   busy, 0);
    check({pfx, "_err"},    err, 0);
    check({pfx, "_sent"},   sent_count, 0);
  endtask

  initial begin
    logic [7:0] got_ids [8];
    int n;
    logic err_at_first;
    logic seen_first;
    logic aw_seen;

    step();
    step();
    reset_outputs("rst");
    rst = 1'b0;
    step();

    // single finish, all ready
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    push_one(48'h1000, 8'h05);
    check("t1_busy_after_push", busy, 1);
    check("t1_aw_not_yet", aw_valid, 0);
    step();
    check("t1_aw_valid", aw_valid, 1);
    check("t1_w_valid", w_valid, 1);
    check("t1_aw_addr", aw_addr, 64'h1000);
    check("t1_w_data", w_data[63:0], 64'h05);
    check("t1_w_data_hi_zero", (w_data[511:64] == '0), 1);
    step();
    check("t1_b_ready", b_ready, 1);
    check("t1_aw_dropped", aw_valid, 0);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("t1_sent", sent_count, 1);
    check("t1_busy_done", busy, 0);
    check("t1_b_ready_idle", b_ready, 0);

    // split phases: aw completes first, w three cycles later
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    push_one(48'h2000, 8'h22);
    step();
    check("t2_aw_valid", aw_valid, 1);
    check("t2_w_valid", w_valid, 1);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    check("t2_aw_drop", aw_valid, 0);
    check("t2_w_hold0", w_valid, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_w_hold", w_valid, 1);
      check("t2_no_resp_yet", b_ready, 0);
    end
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    check("t2_resp", b_ready, 1);
    check("t2_w_drop", w_valid, 0);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("t2_sent", sent_count, 2);

    // fill to Depth, refuse a fifth, drain in order
    for (int i = 0; i < 4; i++) push_one(48'h3000 + 48'(i), 8'h31 + 8'(i));
    check("t3_full_ready", finish_ready, 0);
    check("t3_full_busy", busy, 1);
    finish_valid  = 1'b1;
    finish_addr   = 48'h3999;
    finish_dma_id = 8'h35;
    step();
    finish_valid  = 1'b0;
    check("t3_still_full", finish_ready, 0);
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    b_valid  = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && sent_count != 16'd6; cyc++) begin
      if (w_valid) begin
        if (n < 8) got_ids[n] = w_data[7:0];
        n++;
      end
      step();
    end
    b_valid = 1'b0;
    check("t3_drained_words", 64'(n), 4);
    for (int i = 0; i < 4; i++) check("t3_order", got_ids[i], 64'(8'h31 + 8'(i)));
    check("t3_sent", sent_count, 6);
    check("t3_empty", busy, 0);
    check("t3_ready_again", finish_ready, 1);

    // error on the first response stays sticky
    check("t4_err_before", err, 0);
    b_valid = 1'b1;
    push_one(48'h4000, 8'h41);
    push_one(48'h4100, 8'h42);
    seen_first   = 1'b0;
    err_at_first = 1'b0;
    for (int cyc = 0; cyc < 40 && sent_count != 16'd8; cyc++) begin
      b_error = (sent_count == 16'd6);
      step();
      if (sent_count == 16'd7 && !seen_first) begin
        seen_first   = 1'b1;
        err_at_first = err;
      end
    end
    b_valid = 1'b0;
    b_error = 1'b0;
    check("t4_err_first", err_at_first, 1);
    check("t4_err_sticky", err, 1);
    check("t4_sent", sent_count, 8);
    check("t4_popped", busy, 0);

    // reset while in RESP with two more queued
    push_one(48'h5000, 8'h51);
    push_one(48'h5100, 8'h52);
    push_one(48'h5200, 8'h53);
    for (int cyc = 0; cyc < 20 && !b_ready; cyc++) step();
    check("t5_in_resp", b_ready, 1);
    rst = 1'b1;
    step();
    reset_outputs("t5");
    rst = 1'b0;
    aw_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (aw_valid) aw_seen = 1'b1;
    end
    check("t5_no_aw", aw_seen, 0);
    check("t5_idle", busy, 0);

    // sent counter wraps
    force dut.sent_count_q = 16'hFFFE;
    #1;
    release dut.sent_count_q;
    b_valid = 1'b1;
    push_one(48'h6000, 8'h61);
    for (int cyc = 0; cyc < 20 && sent_count == 16'hFFFE; cyc++) step();
    check("t6_ffff", sent_count, 16'hFFFF);
    push_one(48'h6100, 8'h62);
    for (int cyc = 0; cyc < 20 && sent_count == 16'hFFFF; cyc++) step();
    check("t6_wrap", sent_count, 16'h0000);
    b_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xdma_finish_sender.md
XDMA_FINISH_SENDER -- requirements
Module: xdma_finish_sender

Interface
REQ-001 SHALL have parameters: AddrWidth, 48, remote address width; IdWidth, 8, DMA id width; DataWidth, 512, remote data word width; Depth, 4, finish-queue entries (power of two, >=2).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- finish_valid_i  in  1  finish request from finish manager
- finish_ready_o  out  1  queue accepts request
- finish_addr_i  in  AddrWidth  previous-hop address
- finish_dma_id_i  in  IdWidth  DMA id to report
- aw_valid_o  out  1  address-phase valid
- aw_ready_i  in  1  address-phase ready
- aw_addr_o  out  AddrWidth  target address
- w_valid_o  out  1  data-phase valid
- w_ready_i  in  1  data-phase ready
- w_data_o  out  DataWidth  finish message word
- b_valid_i  in  1  response valid
- b_ready_o  out  1  response ready
- b_error_i  in  1  response carries error
- busy_o  out  1  queue non-empty or FSM not IDLE
- err_o  out  1  sticky error flag
- sent_count_o  out  16  completed finish messages

Function
REQ-003 SHALL buffer {addr, dma_id} in a Depth-entry FIFO; push when finish_valid_i && finish_ready_o.
REQ-004 SHALL drive finish_ready_o = !full, registered state only; no same-cycle pop-to-push bypass when full.
REQ-005 SHALL pop the head entry only on the b handshake; the head stays resident during the transfer.
REQ-006 SHALL implement FSM IDLE -> SEND -> RESP -> IDLE.
REQ-007 IDLE: if FIFO non-empty, go to SEND at the next edge; otherwise hold.
REQ-008 SEND: assert aw_valid_o while aw_done=0 and w_valid_o while w_done=0.
REQ-009 SEND flags: aw_done is set on the aw handshake and w_done on the w handshake; the two phases are independent and either order is legal.
REQ-010 SEND exit: go to RESP at the edge where both phases are complete, including both handshaking in the same cycle; clear both flags on exit.
REQ-011 RESP: assert b_ready_o; on b_valid_i, pop, increment sent_count_o, and go to IDLE.
REQ-012 b_error_i on that handshake SHALL set err_o; err_o is cleared only by reset; no retry is performed.
REQ-013 aw_addr_o SHALL equal the head addr; w_data_o SHALL equal the head dma_id zero-extended to DataWidth (bits [IdWidth-1:0]); both hold stable while the respective valid is high.
REQ-014 A valid SHALL NOT deassert before its handshake; b_ready_o SHALL be 0 outside RESP.
REQ-015 sent_count_o SHALL wrap modulo 2^16.
REQ-016 Latency: a push at edge N into an empty, idle block yields aw_valid_o/w_valid_o high in the cycle after edge N+1.
REQ-017 busy_o SHALL equal (FIFO non-empty) || (state != IDLE).
REQ-018 A simultaneous push and pop (not full) SHALL keep the count unchanged; FIFO pointers SHALL wrap at Depth.

Reset
REQ-019 While rst_i=1 at an edge: state=IDLE, FIFO empty, flags cleared, err_o=0, sent_count_o=0.
REQ-020 Output values during reset: finish_ready_o=1, aw_valid_o=0, w_valid_o=0, b_ready_o=0, busy_o=0.
REQ-021 Reset mid-transfer SHALL discard all queued and in-flight entries without completing handshakes.

Verification
REQ-022 Single finish, all ready=1: push addr=0x1000, id=0x05 -> aw_addr_o=0x1000 and w_data_o=0x05 at cycle N+2; b_valid_i at the next cycle -> sent_count_o=1, busy_o=0.
REQ-023 Split phases: aw_ready_i=1 at cycle 2, w_ready_i=1 at cycle 5 -> aw_valid_o drops after cycle 2; w_valid_o holds until cycle 5; RESP is entered at edge 5.
REQ-024 Fill: with aw_ready_i=0, push 4 entries -> finish_ready_o=0; the 5th push is refused; releasing ready drains ids in FIFO order; sent_count_o=4.
REQ-025 Error: b_error_i=1 on the first response -> err_o=1 and stays 1 after the next clean response; the entry is still popped.
REQ-026 Reset in RESP with 2 entries queued -> all outputs at reset values on the next cycle; no further aw_valid_o.
REQ-027 Wrap: preload sent_count_o near 0xFFFF via 65536 completions (or force) -> count returns to 0x0000.
